// File: rtl/newspaper_vend_if.sv
// newspaper_vend_if: coin acceptor / dispenser signal bundle for the vend controller
interface newspaper_vend_if #(
    parameter int CREDIT_W = 4,
    parameter int STOCK_W  = 4
);
    logic [1:0]          coin;
    logic                cancel;
    logic                restock;
    logic                newspaper;
    logic                change;
    logic                reject;
    logic [CREDIT_W-1:0] credit;
    logic [STOCK_W-1:0]  stock;
    logic                empty;
    logic                busy;

    modport master (
        output coin, cancel, restock,
        input  newspaper, change, reject, credit, stock, empty, busy
    );

    modport slave (
        input  coin, cancel, restock,
        output newspaper, change, reject, credit, stock, empty, busy
    );
endinterface

// File: rtl/newspaper_vend_ctrl.sv
// newspaper_vend_ctrl: coin credit accumulation, dispense, change/refund and stock tracking
module newspaper_vend_ctrl #(
    parameter int PRICE_UNITS = 3,
    parameter int MAX_STOCK   = 8,
    parameter int CREDIT_W    = 4,
    parameter int STOCK_W     = 4
) (
    input logic             clk,
    input logic             rstn,
    newspaper_vend_if.slave bus
);
    typedef enum logic [2:0] {IDLE, COLLECT, DISPENSE, CHANGE, REFUND} state_t;

    localparam logic [CREDIT_W-1:0] PRICE = CREDIT_W'(PRICE_UNITS);
    localparam logic [STOCK_W-1:0]  FULL  = STOCK_W'(MAX_STOCK);

    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d, chg_q, chg_d, sum;
    logic [STOCK_W-1:0]  stock_q, stock_d;
    logic                reject_q, reject_d, open_w, coin_ok, accept;

    // state, credit, change counter, stock and reject pulse registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            credit_q <= '0;
            chg_q    <= '0;
            stock_q  <= FULL;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            chg_q    <= chg_d;
            stock_q  <= stock_d;
            reject_q <= reject_d;
        end
    end

    // coin acceptance, cancel/refund, dispense and change sequencing
    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        chg_d    = chg_q;
        stock_d  = stock_q;
        open_w   = state_q == IDLE || state_q == COLLECT;
        coin_ok  = bus.coin == 2'd1 || bus.coin == 2'd2;
        accept   = coin_ok && open_w && stock_q != '0 && !bus.cancel;
        reject_d = coin_ok && !accept;
        sum      = credit_q + CREDIT_W'(bus.coin);
        case (state_q)
            IDLE, COLLECT: begin
                if (state_q == IDLE && bus.restock)
                    stock_d = FULL;
                if (state_q == COLLECT && bus.cancel) begin
                    state_d  = REFUND;
                    chg_d    = credit_q;
                    credit_d = '0;
                end else if (accept) begin
                    state_d  = sum >= PRICE ? DISPENSE : COLLECT;
                    chg_d    = sum >= PRICE ? sum - PRICE : chg_q;
                    credit_d = sum >= PRICE ? '0 : sum;
                end
            end
            DISPENSE: begin
                stock_d = stock_q - STOCK_W'(1);
                state_d = chg_q != '0 ? CHANGE : IDLE;
            end
            CHANGE, REFUND: begin
                chg_d   = chg_q - CREDIT_W'(1);
                state_d = chg_q > CREDIT_W'(1) ? state_q : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.newspaper = state_q == DISPENSE;
    assign bus.change    = state_q == CHANGE || state_q == REFUND;
    assign bus.busy      = state_q == DISPENSE || state_q == CHANGE || state_q == REFUND;
    assign bus.reject    = reject_q;
    assign bus.credit    = credit_q;
    assign bus.stock     = stock_q;
    assign bus.empty     = stock_q == '0;
endmodule
